// File: rtl/bht_resolver_if.sv
// Bus between fetch/execute and the BHT resolver.
//   master : fetch/execute side. It drives the prediction push and the resolve
//            report, and it receives the queue-full stall, the table update
//            and the redirect.
//   slave  : resolver side.
// Signals:
//   pred_push/pred_pc_4/pred_state/pred_new_pc  prediction recorded at fetch
//   res_valid/res_is_branch/res_taken/res_target outcome of the oldest entry
//   q_full                                        fetch must stall
//   update_en/update_pc_4/update_pc_remote/update_state_old/branch_succ
//                                                 one-cycle BHT write
//   redirect_valid/redirect_pc                    one-cycle flush/redirect
interface bht_resolver_if #(
  parameter int ADDR_W = 10
);
  logic              pred_push;
  logic [ADDR_W-1:0] pred_pc_4;
  logic [1:0]        pred_state;
  logic [ADDR_W-1:0] pred_new_pc;

  logic              res_valid;
  logic              res_is_branch;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;

  logic              q_full;

  logic              update_en;
  logic [ADDR_W-1:0] update_pc_4;
  logic [ADDR_W-1:0] update_pc_remote;
  logic [1:0]        update_state_old;
  logic              branch_succ;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output pred_push, pred_pc_4, pred_state, pred_new_pc,
    output res_valid, res_is_branch, res_taken, res_target,
    input  q_full,
    input  update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ,
    input  redirect_valid, redirect_pc
  );

  modport slave (
    input  pred_push, pred_pc_4, pred_state, pred_new_pc,
    input  res_valid, res_is_branch, res_taken, res_target,
    output q_full,
    output update_en, update_pc_4, update_pc_remote, update_state_old, branch_succ,
    output redirect_valid, redirect_pc
  );
endinterface

// File: rtl/bht_resolver.sv
// Resolution-side partner of the branch history table.
// Every fetch-time prediction is recorded in an in-order circular queue. The
// execute stage resolves the oldest entry. Each resolved branch yields a
// one-cycle table update. A wrong next-PC yields a one-cycle redirect and
// flushes the whole queue.
// Ports:
//   clk, rst_n       clock and synchronous active-low reset
//   bus (slave)      prediction push, resolve report, q_full, update, redirect
//   br_cnt, mis_cnt  resolved branch and misprediction counters (wrapping)
//   overflow         sticky: a push was dropped because the queue was full
//   underflow        sticky: a resolve arrived while the queue was empty
module bht_resolver #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  bht_resolver_if.slave    bus,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mis_cnt,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc_4;
    logic [1:0]        state;
    logic [ADDR_W-1:0] new_pc;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rptr, wptr;
  logic [PTR_W:0]   count;

  entry_t            head;
  logic              full;
  logic              res_accept;
  logic              res_empty;
  logic [ADDR_W-1:0] act_pc;
  logic              mispred;
  logic              push_ok;
  logic              push_ovf;
  logic [PTR_W:0]    count_next;

  logic              update_en_p1;
  logic [ADDR_W-1:0] update_pc_4_p1;
  logic [ADDR_W-1:0] update_pc_remote_p1;
  logic [1:0]        update_state_old_p1;
  logic              branch_succ_p1;
  logic              redirect_valid_p1;
  logic [ADDR_W-1:0] redirect_pc_p1;

  assign head = mem[rptr];
  assign full = (count == FULL_CNT);

  always_comb begin
    res_accept = 1'b0;
    res_empty  = 1'b0;
    act_pc     = head.pc_4;
    mispred    = 1'b0;
    push_ok    = 1'b0;
    push_ovf   = 1'b0;
    count_next = count;

    res_accept = bus.res_valid && (count != '0);
    res_empty  = bus.res_valid && (count == '0);

    if (bus.res_is_branch && bus.res_taken)
      act_pc = bus.res_target;
    mispred = res_accept && (act_pc != head.new_pc);

    // A resolve in the same cycle frees a slot, so a full queue can still
    // take a push. During a flush the push is wrong-path: it is dropped
    // quietly and does not count as an overflow.
    push_ok  = bus.pred_push && (!full || res_accept) && !mispred;
    push_ovf = bus.pred_push && full && !res_accept;

    case ({push_ok, res_accept})
      2'b10:   count_next = count + (PTR_W+1)'(1);
      2'b01:   count_next = count - (PTR_W+1)'(1);
      default: count_next = count;
    endcase
  end

  // Queue storage is not reset; only the pointers and the count say which
  // entries are live.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok)
      mem[wptr] <= '{pc_4: bus.pred_pc_4, state: bus.pred_state, new_pc: bus.pred_new_pc};
  end

  // ---- stage p1: registered update/redirect strobes, pointers, counters ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rptr                <= '0;
      wptr                <= '0;
      count               <= '0;
      br_cnt              <= '0;
      mis_cnt             <= '0;
      overflow            <= 1'b0;
      underflow           <= 1'b0;
      update_en_p1        <= 1'b0;
      update_pc_4_p1      <= '0;
      update_pc_remote_p1 <= '0;
      update_state_old_p1 <= '0;
      branch_succ_p1      <= 1'b0;
      redirect_valid_p1   <= 1'b0;
      redirect_pc_p1      <= '0;
    end else begin
      if (mispred) begin
        rptr  <= '0;
        wptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok)    wptr <= wptr + PTR_W'(1);
        if (res_accept) rptr <= rptr + PTR_W'(1);
        count <= count_next;
      end

      if (push_ovf)  overflow  <= 1'b1;
      if (res_empty) underflow <= 1'b1;

      update_en_p1 <= res_accept && bus.res_is_branch;
      if (res_accept && bus.res_is_branch) begin
        update_pc_4_p1      <= head.pc_4;
        update_pc_remote_p1 <= bus.res_target;
        update_state_old_p1 <= head.state;
        branch_succ_p1      <= bus.res_taken;
        br_cnt              <= br_cnt + CNT_W'(1);
      end

      redirect_valid_p1 <= mispred;
      if (mispred) begin
        redirect_pc_p1 <= act_pc;
        if (bus.res_is_branch)
          mis_cnt <= mis_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.q_full           = full;
  assign bus.update_en        = update_en_p1;
  assign bus.update_pc_4      = update_pc_4_p1;
  assign bus.update_pc_remote = update_pc_remote_p1;
  assign bus.update_state_old = update_state_old_p1;
  assign bus.branch_succ      = branch_succ_p1;
  assign bus.redirect_valid   = redirect_valid_p1;
  assign bus.redirect_pc      = redirect_pc_p1;

endmodule

// File: tb/tb_bht_resolver.sv
// Directed, table-driven bench for bht_resolver (ADDR_W=10, DEPTH=4, CNT_W=16).
// Each table row holds one cycle of inputs and the outputs expected just
// after the following rising edge. A hand-written sequence covers reset
// asserted mid-operation.
module tb_bht_resolver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] br_cnt, mis_cnt;
  logic        overflow, underflow;

  bht_resolver_if #(.ADDR_W(10)) bus ();

  bht_resolver #(.ADDR_W(10), .DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .br_cnt    (br_cnt),
    .mis_cnt   (mis_cnt),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       push;
    logic [9:0] pc4;
    logic [1:0] st;
    logic [9:0] npc;
    logic       rv;
    logic       isbr;
    logic       tk;
    logic [9:0] tgt;
  } in_t;

  typedef struct packed {
    logic        ue;
    logic [9:0]  upc4;
    logic [9:0]  urem;
    logic [1:0]  ust;
    logic        bs;
    logic        rdv;
    logic [9:0]  rpc;
    logic        qf;
    logic [15:0] br;
    logic [15:0] mis;
    logic        ov;
    logic        ud;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t e;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic in_t mk_i(int p, int pc, int st, int np, int r, int b, int t, int tg);
    in_t v;
    v.push = 1'(p);  v.pc4 = 10'(pc); v.st = 2'(st); v.npc = 10'(np);
    v.rv   = 1'(r);  v.isbr = 1'(b);  v.tk = 1'(t);  v.tgt = 10'(tg);
    return v;
  endfunction

  function automatic out_t mk_e(int ue, int upc4, int urem, int ust, int bs,
                                int rdv, int rpc, int qf, int br, int mis, int ov, int ud);
    out_t v;
    v.ue  = 1'(ue);  v.upc4 = 10'(upc4); v.urem = 10'(urem); v.ust = 2'(ust);
    v.bs  = 1'(bs);  v.rdv  = 1'(rdv);   v.rpc  = 10'(rpc);  v.qf  = 1'(qf);
    v.br  = 16'(br); v.mis  = 16'(mis);  v.ov   = 1'(ov);    v.ud  = 1'(ud);
    return v;
  endfunction

  task automatic add(input in_t i, input out_t e);
    vec_t v;
    v.i = i;
    v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input in_t v);
    bus.pred_push     = v.push;
    bus.pred_pc_4     = v.pc4;
    bus.pred_state    = v.st;
    bus.pred_new_pc   = v.npc;
    bus.res_valid     = v.rv;
    bus.res_is_branch = v.isbr;
    bus.res_taken     = v.tk;
    bus.res_target    = v.tgt;
  endtask

  task automatic check(input string name, input out_t exp);
    out_t got;
    got.ue   = bus.update_en;
    got.upc4 = bus.update_pc_4;
    got.urem = bus.update_pc_remote;
    got.ust  = bus.update_state_old;
    got.bs   = bus.branch_succ;
    got.rdv  = bus.redirect_valid;
    got.rpc  = bus.redirect_pc;
    got.qf   = bus.q_full;
    got.br   = br_cnt;
    got.mis  = mis_cnt;
    got.ov   = overflow;
    got.ud   = underflow;
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %p required %p", name, got, exp);
    end
  endtask

  initial begin
    // Columns: push pc4 st npc | rv isbr tk tgt
    // Expected: ue upc4 urem ust bs | rdv rpc | qf br mis ov ud
    // Correct taken prediction: update, no redirect.
    add(mk_i(1,'h011,3,'h040, 0,0,0,0),       mk_e(0,0,0,0,0, 0,0, 0,0,0,0,0));
    add(mk_i(0,0,0,0, 1,1,1,'h040),           mk_e(1,'h011,'h040,3,1, 0,0, 0,1,0,0,0));
    // Misprediction with a wrong-path push in the flush cycle.
    add(mk_i(1,'h020,1,'h020, 0,0,0,0),       mk_e(0,'h011,'h040,3,1, 0,0, 0,1,0,0,0));
    add(mk_i(1,'h055,0,'h000, 1,1,1,'h080),   mk_e(1,'h020,'h080,1,1, 1,'h080, 0,2,1,0,0));
    // Queue must be empty after the flush: this resolve is an underflow.
    add(mk_i(0,0,0,0, 1,1,1,'h123),           mk_e(0,'h020,'h080,1,1, 0,'h080, 0,2,1,0,1));
    // Fill to DEPTH, then an overflowing push.
    add(mk_i(1,'h101,0,'h101, 0,0,0,0),       mk_e(0,'h020,'h080,1,1, 0,'h080, 0,2,1,0,1));
    add(mk_i(1,'h102,1,'h102, 0,0,0,0),       mk_e(0,'h020,'h080,1,1, 0,'h080, 0,2,1,0,1));
    add(mk_i(1,'h103,2,'h103, 0,0,0,0),       mk_e(0,'h020,'h080,1,1, 0,'h080, 0,2,1,0,1));
    add(mk_i(1,'h104,3,'h104, 0,0,0,0),       mk_e(0,'h020,'h080,1,1, 0,'h080, 1,2,1,0,1));
    add(mk_i(1,'h105,0,'h105, 0,0,0,0),       mk_e(0,'h020,'h080,1,1, 0,'h080, 1,2,1,1,1));
    // Push and resolve together while full: count stays at DEPTH.
    add(mk_i(1,'h106,1,'h106, 1,1,0,'h3FF),   mk_e(1,'h101,'h3FF,0,0, 0,'h080, 1,3,1,1,1));
    // Drain in FIFO order across the pointer wrap.
    add(mk_i(0,0,0,0, 1,1,0,'h200),           mk_e(1,'h102,'h200,1,0, 0,'h080, 0,4,1,1,1));
    add(mk_i(0,0,0,0, 1,1,0,'h201),           mk_e(1,'h103,'h201,2,0, 0,'h080, 0,5,1,1,1));
    add(mk_i(0,0,0,0, 1,1,0,'h202),           mk_e(1,'h104,'h202,3,0, 0,'h080, 0,6,1,1,1));
    add(mk_i(0,0,0,0, 1,1,0,'h203),           mk_e(1,'h106,'h203,1,0, 0,'h080, 0,7,1,1,1));
    add(mk_i(1,'h107,2,'h107, 0,0,0,0),       mk_e(0,'h106,'h203,1,0, 0,'h080, 0,7,1,1,1));
    add(mk_i(0,0,0,0, 1,1,0,'h204),           mk_e(1,'h107,'h204,2,0, 0,'h080, 0,8,1,1,1));
    // Non-branch predicted taken: redirect to pc_4, no update, counters unchanged.
    add(mk_i(1,'h030,2,'h100, 0,0,0,0),       mk_e(0,'h107,'h204,2,0, 0,'h080, 0,8,1,1,1));
    add(mk_i(0,0,0,0, 1,0,0,'h000),           mk_e(0,'h107,'h204,2,0, 1,'h030, 0,8,1,1,1));
    add(mk_i(0,0,0,0, 0,0,0,0),               mk_e(0,'h107,'h204,2,0, 0,'h030, 0,8,1,1,1));
    // Branch predicted taken but not taken: redirect to the fall-through PC.
    add(mk_i(1,'h040,3,'h0A0, 0,0,0,0),       mk_e(0,'h107,'h204,2,0, 0,'h030, 0,8,1,1,1));
    add(mk_i(0,0,0,0, 1,1,0,'h0A0),           mk_e(1,'h040,'h0A0,3,0, 1,'h040, 0,9,2,1,1));

    rst_n = 1'b0;
    drive(mk_i(0,0,0,0, 0,0,0,0));
    repeat (2) @(posedge clk);
    #1 check("reset", mk_e(0,0,0,0,0, 0,0, 0,0,0,0,0));
    @(negedge clk) rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk) drive(tbl[k].i);
      @(posedge clk);
      #1 check($sformatf("vec%0d", k), tbl[k].e);
    end

    // Reset while three entries are queued and a resolve is pending.
    @(negedge clk) drive(mk_i(1,'h010,1,'h010, 0,0,0,0));
    @(negedge clk) drive(mk_i(1,'h011,2,'h011, 0,0,0,0));
    @(negedge clk) drive(mk_i(1,'h012,3,'h012, 0,0,0,0));
    @(negedge clk) begin
      drive(mk_i(0,0,0,0, 1,1,1,'h1F0));
      rst_n = 1'b0;
    end
    @(posedge clk);
    #1 check("mid_reset", mk_e(0,0,0,0,0, 0,0, 0,0,0,0,0));
    @(negedge clk) begin
      rst_n = 1'b1;
      drive(mk_i(0,0,0,0, 0,0,0,0));
    end
    @(posedge clk);
    #1 check("after_reset", mk_e(0,0,0,0,0, 0,0, 0,0,0,0,0));
    // The entries were discarded, so this resolve finds an empty queue.
    @(negedge clk) drive(mk_i(0,0,0,0, 1,1,1,'h1F0));
    @(posedge clk);
    #1 check("discarded", mk_e(0,0,0,0,0, 0,0, 0,0,0,0,1));
    @(negedge clk) drive(mk_i(0,0,0,0, 0,0,0,0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bht_resolver.md
# bht_resolver

Resolution-side partner of the branch history table. It records each fetch-time prediction in an in-order queue and compares it against the outcome reported by the execute stage. For every branch it produces the one-cycle table update (`update_en`, `update_pc_4`, `update_pc_remote`, `update_state_old`, `branch_succ`). On a misprediction it issues a pipeline redirect/flush.

## Interface
- `ADDR_W`, default 10: instruction address width, equal to `IM_ADDR_BIT`.
- `DEPTH`, default 4: in-flight prediction queue depth; must be a power of two, at least 2.
- `CNT_W`, default 16: statistics counter width.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `pred_push` in 1: fetch records a prediction this cycle.
- `pred_pc_4` in ADDR_W: PC+4 of the fetched instruction (table key).
- `pred_state` in 2: table state returned at fetch (`guess_state`).
- `pred_new_pc` in ADDR_W: predicted next PC (`guess_new_pc`).
- `res_valid` in 1: execute resolves the oldest queued instruction.
- `res_is_branch` in 1: resolved instruction is a conditional branch.
- `res_taken` in 1: actual branch outcome.
- `res_target` in ADDR_W: computed branch target, valid whenever `res_is_branch`.
- `q_full` out 1: queue holds DEPTH entries; fetch must stall (combinational from count).
- `update_en` out 1: registered one-cycle BHT write strobe.
- `update_pc_4`, `update_pc_remote` out ADDR_W: BHT write key and target.
- `update_state_old` out 2: queued `pred_state` for the resolved branch.
- `branch_succ` out 1: actual taken.
- `redirect_valid` out 1: registered one-cycle flush/redirect strobe.
- `redirect_pc` out ADDR_W: correct next PC.
- `br_cnt`, `mis_cnt` out CNT_W: resolved branches and mispredictions; wrap modulo 2^CNT_W.
- `overflow`, `underflow` out 1: sticky error flags, cleared only by reset.

## Operation
- Queue is a circular buffer of `{pc_4, state, new_pc}` with read and write pointers of log2(DEPTH) bits (wrap naturally) and a count of log2(DEPTH)+1 bits.
- Push: if not full, or if full with an accepted resolve in the same cycle, write the entry at wptr and advance wptr. Otherwise drop the push and set `overflow`.
- Resolve with count 0: ignored; no strobes; set `underflow`.
- Resolve with count > 0: pop the head and compute the actual next PC, `act = (res_is_branch && res_taken) ? res_target : head.pc_4`. Mispredict when `act != head.new_pc`.
- Branch resolve, next cycle:
  - `update_en=1`, `update_pc_4=head.pc_4`, `update_pc_remote=res_target`, `update_state_old=head.state`, `branch_succ=res_taken`.
  - `br_cnt` increments.
- Non-branch resolve: no update and no count change. A redirect still occurs if fetch predicted taken (for example, an aliasing entry).
- Mispredict, next cycle: `redirect_valid=1` and `redirect_pc=act`. `mis_cnt` increments when the instruction is a branch.
- Mispredict flush: rptr, wptr and count are all cleared on the same edge. A same-cycle push is wrong-path and is dropped without setting `overflow`.
- Update and redirect outputs hold their last values while the strobes are low. The strobes are 0 whenever no resolve occurred in the previous cycle.

## Timing
- Reset (rst_n low at an edge): all outputs 0, `q_full=0`, count 0, pointers 0, counters 0, flags 0. Queue contents are don't-care.
- Reset asserted mid-operation discards all entries. Strobes registered for the following cycle are suppressed (0).
- Resolve-to-strobe latency is exactly 1 cycle. Resolve throughput is 1 per cycle.
- A push is visible to a resolve no earlier than the next cycle. No bypass is made from a same-cycle push to a resolve on an empty queue; that case is an underflow.
- `q_full` reflects count after the previous edge. A push and a resolve in the same cycle leave count unchanged.
- Pointer wrap: the entry after DEPTH-1 is index 0. Ordering must be preserved across wrap.

## Test plan
1. Reset → all outputs 0. Then push pc_4=0x011, state=11, new_pc=0x040, and resolve branch taken, target 0x040 → next cycle `update_en=1`, 0x011/0x040/11/1, `redirect_valid=0`, `br_cnt=1`.
2. Push 0x020/01/0x020, resolve branch taken, target 0x080 → `update_en=1`, `redirect_valid=1`, `redirect_pc=0x080`, `mis_cnt=1`. The queue is empty afterwards, and a push in the flush cycle is dropped with `overflow=0`.
3. Push 4 entries → `q_full=1`. A 5th push alone → `overflow=1`. Push and resolve in the same cycle while full → count stays 4. Resolve 6 times in order → heads returned FIFO across pointer wrap.
4. Resolve on an empty queue → no strobes, `underflow=1`, counters unchanged.
5. Non-branch entry 0x030/10/0x100 resolved with `res_is_branch=0` → `update_en=0`, `redirect_valid=1`, `redirect_pc=0x030`, `br_cnt` and `mis_cnt` unchanged.
6. Assert rst_n low for one cycle while 3 entries are queued and a resolve is pending → strobes 0 next cycle, `q_full=0`, counters and flags 0.
